gray_code_counter: RTL and testbench

Parametrised up/down counter that holds its state in binary and presents binary and Gray-coded outputs from the same clock edge.
- Generalises the fixed 4-bit binary-to-Gray converter to WIDTH bits.
- Adds enable, direction, parallel load (binary or Gray), a saturate/wrap mode and terminal/wrap flags.
- Used as a pointer source for clock-domain-crossing FIFOs and as a position counter for Gray-coded encoders.

---
 rtl/gray_code_counter_pkg.sv | 29 ++
 rtl/gray_code_counter_gray2bin_conv.sv | 14 +
 rtl/gray_code_counter.sv | 103 ++++++++++
 tb/tb_gray_code_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_code_counter_pkg.sv
// Shared binary/Gray helpers and step encoding for Gray-coded counters and CDC FIFO pointers.
// The helpers work on GC_MAX_WIDTH bits; callers zero-extend narrower values and truncate the result.
package gray_code_counter_pkg;

  localparam int GC_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_INC  = 2'd2,
    STEP_DEC  = 2'd3
  } step_e;

  // Zero upper bits pass through both conversions unchanged, so a narrow value
  // survives widening and truncation.
  function automatic logic [GC_MAX_WIDTH-1:0] bin2gray(input logic [GC_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GC_MAX_WIDTH-1:0] gray2bin(input logic [GC_MAX_WIDTH-1:0] gray);
    logic [GC_MAX_WIDTH-1:0] bin;
    bin[GC_MAX_WIDTH-1] = gray[GC_MAX_WIDTH-1];
    for (int i = GC_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_code_counter_gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Independent reduction per bit avoids a self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_code_counter.sv
// Up/down counter holding its state in binary, with registered binary and Gray outputs,
// parallel load (binary or Gray), optional saturation, wrap pulse and terminal flag.
module gray_code_counter
  import gray_code_counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter int              SATURATE  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [WIDTH-1:0] ZERO       = '0;
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);
  localparam bit               SAT        = (SATURATE != 0);

  if (WIDTH < 2 || WIDTH > GC_MAX_WIDTH) begin : g_width_check
    $error("gray_code_counter: WIDTH out of range");
  end

  logic [WIDTH-1:0] load_bin_conv;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;
  logic             is_max;
  logic             is_min;
  step_e            step;

  gray2bin_conv #(
    .WIDTH(WIDTH)
  ) u_load_conv (
    .gray(load_val),
    .bin (load_bin_conv)
  );

  assign load_bin = load_is_gray ? load_bin_conv : load_val;
  assign is_max   = (bin_q == ALL_ONES);
  assign is_min   = (bin_q == ZERO);
  assign at_term  = up ? is_max : is_min;

  always_comb begin
    step = STEP_HOLD;
    if (load) begin
      step = STEP_LOAD;
    end else if (en) begin
      step = up ? STEP_INC : STEP_DEC;
    end
  end

  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    case (step)
      STEP_LOAD: bin_next = load_bin;
      STEP_INC: begin
        if (!is_max) begin
          bin_next = bin_q + ONE;
        end else if (!SAT) begin
          bin_next  = ZERO;
          wrap_next = 1'b1;
        end
      end
      STEP_DEC: begin
        if (!is_min) begin
          bin_next = bin_q - ONE;
        end else if (!SAT) begin
          bin_next  = ALL_ONES;
          wrap_next = 1'b1;
        end
      end
      default: bin_next = bin_q;
    endcase
  end

  // Gray is registered from the next binary value so both outputs leave the same flops.
  assign gray_next = WIDTH'(bin2gray(GC_MAX_WIDTH'(bin_next)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= RESET_VAL;
      gray_q <= RESET_GRAY;
      wrap   <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap   <= wrap_next;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: wrapping, saturating, RESET_VAL = 5 and WIDTH = 2 instances.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic       load_is_gray;
  logic [3:0] load_val;

  logic [3:0] bin_q, gray_q, sat_bin, sat_gray, rv_bin, rv_gray;
  logic       wrap, at_term, sat_wrap, sat_at_term, rv_wrap, rv_at_term;
  logic [1:0] w2_bin, w2_gray;
  logic       w2_wrap, w2_at_term;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_code_counter #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'd0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val), .bin_q(bin_q), .gray_q(gray_q), .wrap(wrap), .at_term(at_term));

  gray_code_counter #(.WIDTH(4), .SATURATE(1), .RESET_VAL(4'd0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val), .bin_q(sat_bin), .gray_q(sat_gray), .wrap(sat_wrap), .at_term(sat_at_term));

  gray_code_counter #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'd5)) u_rv5 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val), .bin_q(rv_bin), .gray_q(rv_gray), .wrap(rv_wrap), .at_term(rv_at_term));

  gray_code_counter #(.WIDTH(2), .SATURATE(0), .RESET_VAL(2'd0)) u_w2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_is_gray(load_is_gray),
    .load_val(load_val[1:0]), .bin_q(w2_bin), .gray_q(w2_gray), .wrap(w2_wrap), .at_term(w2_at_term));

  typedef struct {
    logic       load;
    logic       lg;
    logic [3:0] lval;
    logic       en;
    logic       up;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
    logic       term;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ld, input logic lg, input logic [3:0] lval,
                              input logic e, input logic u, input logic [3:0] b,
                              input logic [3:0] g, input logic w, input logic t);
    vec_t v;
    v.load = ld; v.lg = lg; v.lval = lval; v.en = e; v.up = u;
    v.bin = b; v.gray = g; v.wrap = w; v.term = t;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic lg, input logic [3:0] lval,
                       input logic e, input logic u);
    load = ld; load_is_gray = lg; load_val = lval; en = e; up = u;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_gray;
    logic [3:0] prev_bin;
    logic [3:0] inc_gray [16];
    logic [1:0] w2_exp_bin [8];
    logic       w2_exp_wrap [8];

    inc_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    w2_exp_bin  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    w2_exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // 16 increments from 0: wrap only on the return to 0, terminal at 15
    for (int i = 1; i <= 16; i++) begin
      add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'(i % 16), inc_gray[i-1], (i == 16), (i == 15));
    end
    add(1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 4'b1100, 4'b1010, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'b0101, 1'b0, 1'b1, 4'b0101, 4'b0111, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111, 4'b1000, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1110, 4'b1001, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0, 1'b1);
    add(1'b1, 1'b0, 4'b0011, 1'b1, 1'b1, 4'b0011, 4'b0010, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0011, 4'b0010, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0010, 4'b0011, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0011, 4'b0010, 1'b0, 1'b0);
    add(1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    #12;
    check("reset_bin", bin_q, 4'b0000);
    check("reset_gray", gray_q, 4'b0000);
    check("reset_wrap", 4'(wrap), 4'd0);
    check("reset_term", 4'(at_term), 4'd1);
    check("reset_rv_bin", rv_bin, 4'b0101);
    check("reset_rv_gray", rv_gray, 4'b0111);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].lg, vecs[i].lval, vecs[i].en, vecs[i].up);
      prev_gray = gray_q;
      prev_bin  = bin_q;
      step();
      check($sformatf("v%0d_bin", i), bin_q, vecs[i].bin);
      check($sformatf("v%0d_gray", i), gray_q, vecs[i].gray);
      check($sformatf("v%0d_wrap", i), 4'(wrap), 4'(vecs[i].wrap));
      check($sformatf("v%0d_term", i), 4'(at_term), 4'(vecs[i].term));
      if (vecs[i].en && !vecs[i].load && bin_q != prev_bin) begin
        check($sformatf("v%0d_gray_one_bit", i), 4'($countones(prev_gray ^ gray_q)), 4'd1);
      end
    end

    // saturating instance held at all-ones, then reversed
    drive(1'b1, 1'b0, 4'b1111, 1'b0, 1'b1);
    step();
    check("sat_load_bin", sat_bin, 4'b1111);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("sat_hold%0d_bin", i), sat_bin, 4'b1111);
      check($sformatf("sat_hold%0d_wrap", i), 4'(sat_wrap), 4'd0);
      check($sformatf("sat_hold%0d_term", i), 4'(sat_at_term), 4'd1);
      if (i == 0) check("wrap_ref_pulse", 4'(wrap), 4'd1);
    end
    up = 1'b0;
    step();
    check("sat_down_bin", sat_bin, 4'b1110);
    check("sat_down_gray", sat_gray, 4'b1001);
    check("sat_down_term", 4'(sat_at_term), 4'd0);
    drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step();
    check("sat_floor_bin", sat_bin, 4'b0000);
    check("sat_floor_wrap", 4'(sat_wrap), 4'd0);
    check("sat_floor_term", 4'(sat_at_term), 4'd1);

    // WIDTH = 2 continuous counting gives a wrap every fourth edge
    drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("w2_%0d_bin", i), 4'(w2_bin), 4'(w2_exp_bin[i]));
      check($sformatf("w2_%0d_wrap", i), 4'(w2_wrap), 4'(w2_exp_wrap[i]));
    end

    // asynchronous reset mid-cycle, then restart from RESET_VAL
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    check("async_rv_bin", rv_bin, 4'b0101);
    check("async_rv_gray", rv_gray, 4'b0111);
    check("async_rv_wrap", 4'(rv_wrap), 4'd0);
    check("async_dut_bin", bin_q, 4'b0000);
    step();
    check("async_hold_rv_bin", rv_bin, 4'b0101);
    rst = 1'b0;
    prev_gray = rv_gray;
    step();
    check("restart1_rv_bin", rv_bin, 4'b0110);
    check("restart1_rv_gray", rv_gray, 4'b0101);
    check("restart1_one_bit", 4'($countones(prev_gray ^ rv_gray)), 4'd1);
    prev_gray = rv_gray;
    step();
    check("restart2_rv_bin", rv_bin, 4'b0111);
    check("restart2_rv_gray", rv_gray, 4'b0100);
    check("restart2_one_bit", 4'($countones(prev_gray ^ rv_gray)), 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
